// File: rtl/md_ctrl_pkg.sv
// Shared CPU definitions for the multiply/divide unit:
// MD_Op encodings and controller state encoding.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_ctrl.sv
// HI/LO multiply-divide controller: computes at accept,
// holds MD_Busy for a fixed latency, then commits to HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MD_Start,
  input  logic [2:0]  MD_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        MD_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0] smul;
  logic [63:0] umul;
  logic        b_zero;
  logic        div_ovf;
  logic [31:0] sdiv_b;
  logic [31:0] udiv_b;
  logic [31:0] sq, sr;
  logic [31:0] uq, ur;
  logic        accept;
  md_op_e      op;

  assign op = md_op_e'(MD_Op);

  assign smul = $signed({{32{A[31]}}, A})
              * $signed({{32{B[31]}}, B});
  assign umul = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 for /0 (result discarded) and for
  // MIN/-1, where A/1 already gives q=0x80000000, r=0.
  assign b_zero  = (B == 32'd0);
  assign div_ovf = (A == 32'h8000_0000)
                && (B == 32'hFFFF_FFFF);
  assign sdiv_b  = (b_zero || div_ovf) ? 32'd1 : B;
  assign udiv_b  = b_zero ? 32'd1 : B;

  assign sq = $signed(A) / $signed(sdiv_b);
  assign sr = $signed(A) % $signed(sdiv_b);
  assign uq = A / udiv_b;
  assign ur = A % udiv_b;

  assign accept = (state_q == ST_IDLE)
               && MD_Start && !Flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            op == OP_MULT: begin
              pend_d  = smul;
              cnt_d   = MULT_LD;
              state_d = ST_BUSY;
            end
            op == OP_MULTU: begin
              pend_d  = umul;
              cnt_d   = MULT_LD;
              state_d = ST_BUSY;
            end
            op == OP_DIV: begin
              pend_d  = b_zero ? {hi_q, lo_q} : {sr, sq};
              cnt_d   = DIV_LD;
              state_d = ST_BUSY;
            end
            op == OP_DIVU: begin
              pend_d  = b_zero ? {hi_q, lo_q} : {ur, uq};
              cnt_d   = DIV_LD;
              state_d = ST_BUSY;
            end
            op == OP_MTHI: hi_d = A;
            op == OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign MD_Busy = (state_q == ST_BUSY);
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, cycles MD_BUSY stays high for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, cycles MD_BUSY stays high for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port MD_Start  input  1  request from E stage, qualified by MD_Op.
REQ-006 SHALL have port MD_Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port Flush  input  1  exception/eret at MEM; cancels a same-cycle MD_Start.
REQ-010 SHALL have port MD_Busy  output  1  registered, high while an operation is in flight.
REQ-011 SHALL have port HI  output  32  HI register, feeds RF write-data select code 3.
REQ-012 SHALL have port LO  output  32  LO register, feeds RF write-data select code 4.

Function
REQ-013 SHALL implement two states, IDLE and BUSY, plus a down-counter and 64-bit pending-result register.
REQ-014 SHALL accept MD_Start only in IDLE with Flush low; otherwise MD_Start is ignored with no state change.
REQ-015 SHALL, on accepted MULT/MULTU/DIV/DIVU, compute the result from A/B at that edge into the pending register, load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES) and enter BUSY.
REQ-016 SHALL hold MD_Busy high for exactly N cycles after the accepting edge; on the edge where counter is 0 in BUSY, write pending to HI/LO, drop MD_Busy, return to IDLE.
REQ-017 SHALL leave HI/LO unchanged throughout BUSY until the commit edge.
REQ-018 SHALL, on accepted MTHI/MTLO, write A to HI/LO at that edge, with no BUSY entry and MD_Busy staying low.
REQ-019 SHALL treat op codes 6-7 as no-ops.
REQ-020 SHALL form the MULT product as signed 32x32 to 64 and MULTU as unsigned; HI = [63:32], LO = [31:0].
REQ-021 SHALL set LO = quotient and HI = remainder for DIV/DIVU, truncating toward zero, with the remainder taking the sign of the dividend for DIV.
REQ-022 SHALL produce LO = 0x80000000 and HI = 0 for DIV of 0x80000000 by 0xFFFFFFFF.
REQ-023 SHALL, for divisor 0, run the full DIV_CYCLES busy period and leave HI/LO unchanged at commit.
REQ-024 SHALL not let Flush during BUSY abort the in-flight operation; it completes and commits.
REQ-025 SHALL accept a new MD_Start on the cycle after the commit edge, not on the commit cycle itself.

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, counter 0, pending 0, HI 0, LO 0, MD_Busy 0, discarding any in-flight operation.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts; MD_Start sampled on that edge is honoured.

Structure
REQ-028 SHALL take MD_Op encodings and state encodings from the shared CPU definitions package, not local literals.
REQ-029 SHALL be a single module with no sub-module; the arithmetic uses inline operators and the counter is local.

Verification
REQ-030 SHALL cover MULT with A=0xFFFFFFFE, B=3 -> MD_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL cover DIV with A=0xFFFFFFF9 (-7), B=2 -> MD_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 SHALL cover divide by zero after MTHI 0x11, MTLO 0x22: DIVU B=0 -> 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
REQ-033 SHALL cover MD_Start with Flush high -> no busy, HI/LO unchanged; Flush pulsed mid-MULT -> result still commits at cycle 5.
REQ-034 SHALL cover MD_Start held high during BUSY with different operands -> ignored, and the original result commits.
REQ-035 SHALL cover rst_n low at busy cycle 3 of DIV -> MD_Busy, HI and LO all 0 immediately, and no later commit.
